acc_alu: RTL and testbench
==========================

# acc_alu

Parametrised accumulator ALU with a valid/ready operation port, a four-state power/run/error FSM, and a multi-cycle shift-add multiplier. It sits between the operand input registers and the result output of the calculator datapath. One accumulator register is both the left operand and the destination of every operation. Overflow on ADD, SUB or MUL moves the block into a sticky error state that only an explicit clear leaves.

## Interface
- WIDTH, 8, datapath and accumulator width in bits (≥2)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset: synchronous, active-high, highest priority
- on  in  1  power enable; 0 forces OFF at the next edge
- op_valid  in  1  operation request
- op_ready  out  1  block accepts an operation this cycle
- op_code  in  3  000 LOAD, 001 AND, 010 OR, 011 XOR, 100 NOT, 101 ADD, 110 SUB, 111 MUL
- operand  in  WIDTH  right operand, sampled on accept
- err_clear  in  1  leave ERROR
- acc  out  WIDTH  accumulator value (registered)
- result_valid  out  1  one-cycle pulse: acc holds a new result
- error  out  1  high exactly while state = ERROR
- state  out  2  00 OFF, 01 READY, 10 RUN, 11 ERROR

## Operation
- An operation is accepted on an edge where op_valid=1 and op_ready=1. op_ready=1 only in READY.
- Single-cycle ops write acc at the accept edge:
  - LOAD: acc←operand
  - AND, OR, XOR: acc op operand
  - NOT: ~acc; operand is ignored
  - ADD: acc+operand, truncated to WIDTH
  - SUB: acc−operand, mod 2^WIDTH
- All arithmetic is unsigned.
- Overflow conditions:
  - ADD: carry-out=1.
  - SUB: borrow (operand > acc).
  - MUL: full 2·WIDTH product ≥ 2^WIDTH.
- On overflow, acc still takes the truncated result.
- MUL: the accept edge latches the multiplicand (acc), the multiplier (operand) and a cleared 2·WIDTH partial product, then enters RUN. RUN processes one multiplier bit per cycle for exactly WIDTH cycles. acc is not modified during RUN.
- FSM, with rst taking priority over every transition:
  - OFF: on=1 → READY.
  - READY: accept of a non-MUL op → ERROR if overflow, else stay READY. Accept of MUL → RUN.
  - RUN: at the edge ending the WIDTH-th cycle, acc←product[WIDTH-1:0]. The next state is ERROR if product[2WIDTH-1:WIDTH]≠0, else READY.
  - ERROR: err_clear=1 → READY; acc is unchanged. op_valid is ignored.
  - Any state with on=0 → OFF. on=0 beats err_clear and a completing MUL. An aborted MUL leaves acc unchanged and raises no result_valid.
- rst: state=OFF, acc=0, result_valid=0, error=0, op_ready=0, and the multiplier counter and registers are cleared. rst asserted mid-RUN aborts the MUL.

## Timing
- Single-cycle op accepted at edge N: the new acc and result_valid=1 are visible during cycle N+1, and state reflects ERROR in that same cycle.
- MUL accepted at edge N: state=RUN and op_ready=0 from cycle N+1 through cycle N+WIDTH. The new acc, result_valid=1, and state READY or ERROR are visible in cycle N+WIDTH+1.
- Back-to-back single-cycle ops are accepted on consecutive edges, giving full throughput.
- result_valid pulses exactly once per completed op, including ops that overflow. It is never asserted in OFF.
- error and state are registered. There is no combinational path from op_valid to op_ready.

## Test plan
- Reset and power-up: rst for 2 cycles with on=0 → acc=0x00, state=00, op_ready=0. Then on=1 → state=01 and op_ready=1 one cycle later.
- Logic ops (WIDTH=8), issued back-to-back: LOAD 0x3C, AND 0x0F, XOR 0xFF, NOT → acc=0x3C, 0x0C, 0xF3, 0x0C in consecutive cycles. result_valid stays high for 4 cycles. error=0 throughout.
- Add/sub overflow:
  - LOAD 200, ADD 100 → acc=0x2C, state=11, error=1, op_ready=0.
  - op_valid with LOAD 0x55 while in ERROR → ignored, acc stays 0x2C.
  - err_clear → state=01 with acc=0x2C.
  - Then LOAD 5, SUB 7 → acc=0xFE, state=11.
- Multiply:
  - LOAD 12, MUL 10 → op_ready=0 for 8 cycles; acc=120 in cycle N+9; state=01.
  - LOAD 16, MUL 16 → acc=0x00, state=11.
  - WIDTH=16: 300×200 → acc=60000 with no error, after a 16-cycle RUN.
- Abort paths:
  - on=0 in the 3rd RUN cycle → state=00 next cycle, acc keeps the pre-MUL value, no result_valid.
  - rst mid-RUN → all reset values next cycle.
  - In ERROR, err_clear=1 together with on=0 → state=00.

Source files
------------

// File: rtl/acc_alu_if.sv
// Operation/result port bundle for acc_alu.
// The master drives requests; the slave (acc_alu) drives accumulator and status.
interface acc_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             on;
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] operand;
  logic             err_clear;
  logic [WIDTH-1:0] acc;
  logic             result_valid;
  logic             error;
  logic [1:0]       state;

  modport master (
    output on, op_valid, op_code, operand, err_clear,
    input  op_ready, acc, result_valid, error, state
  );

  modport slave (
    input  on, op_valid, op_code, operand, err_clear,
    output op_ready, acc, result_valid, error, state
  );
endinterface

// File: rtl/acc_alu.sv
// Accumulator ALU: single-cycle logic/add/sub ops, shift-add multiply over WIDTH
// cycles, and a sticky error state entered on any arithmetic overflow.
module acc_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  acc_alu_if.slave   bus
);

  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned CntW  = $clog2(WIDTH);

  localparam logic [2:0] opLoad = 3'b000;
  localparam logic [2:0] opAnd  = 3'b001;
  localparam logic [2:0] opOr   = 3'b010;
  localparam logic [2:0] opXor  = 3'b011;
  localparam logic [2:0] opNot  = 3'b100;
  localparam logic [2:0] opAdd  = 3'b101;
  localparam logic [2:0] opSub  = 3'b110;
  localparam logic [2:0] opMul  = 3'b111;

  typedef enum logic [1:0] {
    stOff   = 2'b00,
    stReady = 2'b01,
    stRun   = 2'b10,
    stError = 2'b11
  } stateT;

  stateT            stateQ;
  logic [WIDTH-1:0] accQ;
  logic             resultValidQ;
  logic             opReadyQ;
  logic             errorQ;
  logic [ProdW-1:0] mcandQ;
  logic [WIDTH-1:0] mplierQ;
  logic [ProdW-1:0] productQ;
  logic [CntW-1:0]  countQ;

  logic [WIDTH:0]   addExt;
  logic [WIDTH:0]   subExt;
  logic [WIDTH-1:0] aluRes;
  logic             aluOvf;
  logic [ProdW-1:0] productNext;
  logic             lastStep;

  // Extra top bit carries the ADD carry-out / SUB borrow.
  assign addExt = {1'b0, accQ} + {1'b0, bus.operand};
  assign subExt = {1'b0, accQ} - {1'b0, bus.operand};

  always_comb begin
    aluRes = accQ;
    aluOvf = 1'b0;
    case (bus.op_code)
      opLoad:  aluRes = bus.operand;
      opAnd:   aluRes = accQ & bus.operand;
      opOr:    aluRes = accQ | bus.operand;
      opXor:   aluRes = accQ ^ bus.operand;
      opNot:   aluRes = ~accQ;
      opAdd: begin
        aluRes = addExt[WIDTH-1:0];
        aluOvf = addExt[WIDTH];
      end
      opSub: begin
        aluRes = subExt[WIDTH-1:0];
        aluOvf = subExt[WIDTH];
      end
      default: aluRes = accQ;
    endcase
  end

  // One multiplier bit per RUN cycle; the shifted multiplicand is added when the bit is set.
  assign productNext = productQ + (mplierQ[0] ? mcandQ : {ProdW{1'b0}});
  assign lastStep    = (countQ == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ       <= stOff;
      accQ         <= '0;
      resultValidQ <= 1'b0;
      opReadyQ     <= 1'b0;
      errorQ       <= 1'b0;
      mcandQ       <= '0;
      mplierQ      <= '0;
      productQ     <= '0;
      countQ       <= '0;
    end else begin
      resultValidQ <= 1'b0;
      if (!bus.on) begin
        stateQ   <= stOff;
        opReadyQ <= 1'b0;
        errorQ   <= 1'b0;
        countQ   <= '0;
      end else begin
        case (stateQ)
          stOff: begin
            stateQ   <= stReady;
            opReadyQ <= 1'b1;
          end
          stReady: begin
            if (bus.op_valid) begin
              if (bus.op_code == opMul) begin
                mcandQ   <= {{WIDTH{1'b0}}, accQ};
                mplierQ  <= bus.operand;
                productQ <= '0;
                countQ   <= '0;
                stateQ   <= stRun;
                opReadyQ <= 1'b0;
              end else begin
                accQ         <= aluRes;
                resultValidQ <= 1'b1;
                if (aluOvf) begin
                  stateQ   <= stError;
                  opReadyQ <= 1'b0;
                  errorQ   <= 1'b1;
                end
              end
            end
          end
          stRun: begin
            productQ <= productNext;
            mcandQ   <= mcandQ << 1;
            mplierQ  <= mplierQ >> 1;
            countQ   <= countQ + CntW'(1);
            if (lastStep) begin
              accQ         <= productNext[WIDTH-1:0];
              resultValidQ <= 1'b1;
              countQ       <= '0;
              if (productNext[ProdW-1:WIDTH] != '0) begin
                stateQ <= stError;
                errorQ <= 1'b1;
              end else begin
                stateQ   <= stReady;
                opReadyQ <= 1'b1;
              end
            end
          end
          stError: begin
            if (bus.err_clear) begin
              stateQ   <= stReady;
              opReadyQ <= 1'b1;
              errorQ   <= 1'b0;
            end
          end
          default: stateQ <= stOff;
        endcase
      end
    end
  end

  assign bus.acc          = accQ;
  assign bus.result_valid = resultValidQ;
  assign bus.op_ready     = opReadyQ;
  assign bus.error        = errorQ;
  assign bus.state        = stateQ;

endmodule

// File: tb/tb_acc_alu.sv
// Scoreboard bench for acc_alu: WIDTH=8 and WIDTH=16 instances, directed vectors,
// expected results queued at issue time and checked by per-instance monitors.
module tb_acc_alu;

  localparam logic [2:0] LOAD = 3'b000;
  localparam logic [2:0] AND_ = 3'b001;
  localparam logic [2:0] XOR_ = 3'b011;
  localparam logic [2:0] NOT_ = 3'b100;
  localparam logic [2:0] ADD  = 3'b101;
  localparam logic [2:0] SUB  = 3'b110;
  localparam logic [2:0] MUL  = 3'b111;

  localparam logic [1:0] S_OFF   = 2'b00;
  localparam logic [1:0] S_READY = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_ERR   = 2'b11;

  typedef struct packed {
    logic [15:0] acc;
    logic [1:0]  st;
  } expT;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  expT  q8[$];
  expT  q16[$];
  expT  e8;
  expT  e16;

  acc_alu_if #(.WIDTH(8))  ifc8 ();
  acc_alu_if #(.WIDTH(16)) ifc16 ();

  acc_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(ifc8));
  acc_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(ifc16));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [2:0] code, input logic [7:0] opnd, input bit push,
                        input logic [7:0] expAcc, input logic [1:0] expSt);
    ifc8.op_valid = 1'b1;
    ifc8.op_code  = code;
    ifc8.operand  = opnd;
    if (push) q8.push_back('{acc: 16'(expAcc), st: expSt});
    tick();
    ifc8.op_valid = 1'b0;
  endtask

  task automatic clearErr8();
    ifc8.err_clear = 1'b1;
    tick();
    ifc8.err_clear = 1'b0;
  endtask

  // Counts RUN cycles until the FSM leaves RUN, bounded.
  task automatic waitRun8(output int n);
    n = 0;
    while (ifc8.state == S_RUN && n < 40) begin
      check("run8_op_ready_low", 32'(ifc8.op_ready), 32'd0);
      tick();
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (ifc8.result_valid === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rv8_unexpected actual=acc 0x%0h state %0d required=no result", ifc8.acc, ifc8.state);
      end else begin
        e8 = q8.pop_front();
        check("rv8_acc", 32'(ifc8.acc), 32'(e8.acc));
        check("rv8_state", 32'(ifc8.state), 32'(e8.st));
      end
    end
  end

  always @(negedge clk) begin
    if (ifc16.result_valid === 1'b1) begin
      if (q16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rv16_unexpected actual=acc 0x%0h state %0d required=no result", ifc16.acc, ifc16.state);
      end else begin
        e16 = q16.pop_front();
        check("rv16_acc", 32'(ifc16.acc), 32'(e16.acc));
        check("rv16_state", 32'(ifc16.state), 32'(e16.st));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    ifc8.on = 1'b0;  ifc8.op_valid = 1'b0;  ifc8.op_code = LOAD;  ifc8.operand = '0;  ifc8.err_clear = 1'b0;
    ifc16.on = 1'b0; ifc16.op_valid = 1'b0; ifc16.op_code = LOAD; ifc16.operand = '0; ifc16.err_clear = 1'b0;
    tick();
    tick();
    check("rst_acc", 32'(ifc8.acc), 32'h00);
    check("rst_state", 32'(ifc8.state), 32'(S_OFF));
    check("rst_op_ready", 32'(ifc8.op_ready), 32'd0);
    check("rst_error", 32'(ifc8.error), 32'd0);

    rst = 1'b0;
    ifc8.on = 1'b1;
    ifc16.on = 1'b1;
    check("pwr_still_off", 32'(ifc8.state), 32'(S_OFF));
    tick();
    check("pwr_state", 32'(ifc8.state), 32'(S_READY));
    check("pwr_op_ready", 32'(ifc8.op_ready), 32'd1);

    // Back-to-back logic ops.
    issue8(LOAD, 8'h3C, 1'b1, 8'h3C, S_READY);
    issue8(AND_, 8'h0F, 1'b1, 8'h0C, S_READY);
    issue8(XOR_, 8'hFF, 1'b1, 8'hF3, S_READY);
    issue8(NOT_, 8'hAA, 1'b1, 8'h0C, S_READY);
    check("logic_error", 32'(ifc8.error), 32'd0);
    tick();

    // ADD overflow, ignored op in ERROR, clear.
    issue8(LOAD, 8'd200, 1'b1, 8'd200, S_READY);
    issue8(ADD,  8'd100, 1'b1, 8'h2C,  S_ERR);
    check("add_ovf_state", 32'(ifc8.state), 32'(S_ERR));
    check("add_ovf_error", 32'(ifc8.error), 32'd1);
    check("add_ovf_op_ready", 32'(ifc8.op_ready), 32'd0);
    ifc8.op_valid = 1'b1; ifc8.op_code = LOAD; ifc8.operand = 8'h55;
    tick();
    tick();
    ifc8.op_valid = 1'b0;
    check("err_ignore_acc", 32'(ifc8.acc), 32'h2C);
    clearErr8();
    check("clr_state", 32'(ifc8.state), 32'(S_READY));
    check("clr_acc", 32'(ifc8.acc), 32'h2C);
    check("clr_error", 32'(ifc8.error), 32'd0);

    // SUB borrow.
    issue8(LOAD, 8'd5, 1'b1, 8'd5,  S_READY);
    issue8(SUB,  8'd7, 1'b1, 8'hFE, S_ERR);
    check("sub_borrow_state", 32'(ifc8.state), 32'(S_ERR));
    clearErr8();

    // Non-overflowing SUB stays READY.
    issue8(LOAD, 8'd9, 1'b1, 8'd9, S_READY);
    issue8(SUB,  8'd9, 1'b1, 8'd0, S_READY);
    check("sub_zero_state", 32'(ifc8.state), 32'(S_READY));

    // MUL 12 x 10.
    issue8(LOAD, 8'd12, 1'b1, 8'd12, S_READY);
    issue8(MUL,  8'd10, 1'b1, 8'd120, S_READY);
    check("mul_run_state", 32'(ifc8.state), 32'(S_RUN));
    waitRun8(n);
    check("mul_run_cycles", 32'(n), 32'd8);
    check("mul_done_state", 32'(ifc8.state), 32'(S_READY));
    check("mul_done_acc", 32'(ifc8.acc), 32'd120);

    // MUL 16 x 16 overflows to exactly 256.
    issue8(LOAD, 8'd16, 1'b1, 8'd16, S_READY);
    issue8(MUL,  8'd16, 1'b1, 8'h00, S_ERR);
    waitRun8(n);
    check("mul_ovf_cycles", 32'(n), 32'd8);
    check("mul_ovf_state", 32'(ifc8.state), 32'(S_ERR));
    check("mul_ovf_error", 32'(ifc8.error), 32'd1);
    clearErr8();

    // MUL 255 x 1 is the largest non-overflowing product with multiplier 1.
    issue8(LOAD, 8'hFF, 1'b1, 8'hFF, S_READY);
    issue8(MUL,  8'd1,  1'b1, 8'hFF, S_READY);
    waitRun8(n);
    check("mul_ff_state", 32'(ifc8.state), 32'(S_READY));

    // Power-off abort in the 3rd RUN cycle.
    issue8(LOAD, 8'h21, 1'b1, 8'h21, S_READY);
    issue8(MUL,  8'd3,  1'b0, 8'h00, S_READY);
    tick();
    tick();
    ifc8.on = 1'b0;
    tick();
    check("abort_off_state", 32'(ifc8.state), 32'(S_OFF));
    check("abort_off_acc", 32'(ifc8.acc), 32'h21);
    check("abort_off_rv", 32'(ifc8.result_valid), 32'd0);
    ifc8.on = 1'b1;
    tick();
    check("abort_repower", 32'(ifc8.state), 32'(S_READY));
    for (int i = 0; i < 10; i++) tick();

    // Reset mid-RUN.
    issue8(LOAD, 8'd7, 1'b1, 8'd7, S_READY);
    issue8(MUL,  8'd9, 1'b0, 8'h00, S_READY);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_acc", 32'(ifc8.acc), 32'h00);
    check("midrst_state", 32'(ifc8.state), 32'(S_OFF));
    check("midrst_op_ready", 32'(ifc8.op_ready), 32'd0);
    check("midrst_error", 32'(ifc8.error), 32'd0);
    check("midrst_rv", 32'(ifc8.result_valid), 32'd0);
    tick();
    check("midrst_ready", 32'(ifc8.state), 32'(S_READY));

    // on=0 beats err_clear in ERROR.
    issue8(LOAD, 8'd5, 1'b1, 8'd5,  S_READY);
    issue8(SUB,  8'd7, 1'b1, 8'hFE, S_ERR);
    ifc8.err_clear = 1'b1;
    ifc8.on = 1'b0;
    tick();
    check("off_beats_clear", 32'(ifc8.state), 32'(S_OFF));
    check("off_error_low", 32'(ifc8.error), 32'd0);
    ifc8.err_clear = 1'b0;
    ifc8.on = 1'b1;
    tick();
    check("off_repower", 32'(ifc8.state), 32'(S_READY));

    // WIDTH=16: 300 x 200 = 60000.
    check("w16_ready", 32'(ifc16.state), 32'(S_READY));
    ifc16.op_valid = 1'b1; ifc16.op_code = LOAD; ifc16.operand = 16'd300;
    q16.push_back('{acc: 16'd300, st: S_READY});
    tick();
    ifc16.op_code = MUL; ifc16.operand = 16'd200;
    q16.push_back('{acc: 16'd60000, st: S_READY});
    tick();
    ifc16.op_valid = 1'b0;
    n = 0;
    while (ifc16.state == S_RUN && n < 40) begin
      tick();
      n++;
    end
    check("w16_run_cycles", 32'(n), 32'd16);
    check("w16_state", 32'(ifc16.state), 32'(S_READY));
    check("w16_acc", 32'(ifc16.acc), 32'd60000);
    check("w16_error", 32'(ifc16.error), 32'd0);

    tick();
    tick();
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q16_drained", 32'(q16.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
